// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard/stall controller for a 5-stage pipeline.
// Produces pipeline-register write enables and flushes from the hazard
// conditions seen in ID/EX/MEM and sequences multi-cycle waits for the
// data memory and the mul/div unit.
// Optional build macro: PIPE_CTRL_PERF_EN adds a 32-bit stall_cnt output
// counting cycles in which the PC is held.
module pipe_ctrl #(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned MDU_MAX_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mdu_start,
  input  logic             mdu_done,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             we_pc,
  output logic             we_ifid,
  output logic             we_idex,
  output logic             we_exmem,
  output logic             we_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             flush_memwb,
  output logic             mdu_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  // Counter must be able to hold MDU_MAX_CYC-1 (index of the last wait cycle).
  localparam int unsigned CNT_W = (MDU_MAX_CYC > 1) ? $clog2(MDU_MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_MAX_CYC - 1);

  // Write-enable / flush vectors, ordered {pc, ifid, idex, exmem, memwb}.
  localparam logic [4:0] WE_ALL  = 5'b11111;
  localparam logic [4:0] WE_NONE = 5'b00000;
  localparam logic [4:0] WE_MDU  = 5'b00011;
  localparam logic [4:0] WE_LU   = 5'b00111;
  // Flush vector ordered {ifid, idex, exmem, memwb}.
  localparam logic [3:0] FL_NONE = 4'b0000;
  localparam logic [3:0] FL_MDU  = 4'b0010;
  localparam logic [3:0] FL_BR   = 4'b1100;
  localparam logic [3:0] FL_LU   = 4'b0100;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_WAIT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic [4:0] we_v;
  logic [3:0] fl_v;
  logic       to_v;
  logic       mem_stall;
  logic       load_use;
  logic       cnt_hit;

  assign mem_stall = dmem_req && !dmem_ready;
  assign load_use  = ex_mem_read && (ex_rd != '0) &&
                     ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign cnt_hit   = (cnt == CNT_LAST);

  // State and MDU wait counter; reset abandons any wait in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and raw enable/flush decode, RUN priority: mem, mdu, branch, load-use.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    we_v      = WE_ALL;
    fl_v      = FL_NONE;
    to_v      = 1'b0;
    case (state)
      RUN: begin
        if (mem_stall) begin
          we_v      = WE_NONE;
          state_nxt = MEM_WAIT;
        end else if (mdu_start) begin
          we_v      = WE_MDU;
          fl_v      = FL_MDU;
          state_nxt = MDU_WAIT;
        end else if (ex_branch_taken) begin
          fl_v = FL_BR;
        end else if (load_use) begin
          we_v = WE_LU;
          fl_v = FL_LU;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt = RUN;
        end else begin
          we_v = WE_NONE;
        end
      end
      MDU_WAIT: begin
        // Memory requests are ignored here: MEM only holds the bubble.
        if (mdu_done) begin
          state_nxt = RUN;
        end else if (cnt_hit) begin
          to_v      = 1'b1;
          state_nxt = RUN;
        end else begin
          we_v    = WE_MDU;
          fl_v    = FL_MDU;
          cnt_nxt = CNT_W'(cnt + 1'b1);
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // Outputs are forced inactive for as long as reset is held.
  always_comb begin
    we_pc       = rst & we_v[4];
    we_ifid     = rst & we_v[3];
    we_idex     = rst & we_v[2];
    we_exmem    = rst & we_v[1];
    we_memwb    = rst & we_v[0];
    flush_ifid  = rst & fl_v[3];
    flush_idex  = rst & fl_v[2];
    flush_exmem = rst & fl_v[1];
    flush_memwb = 1'b0 & fl_v[0];
    mdu_timeout = rst & to_v;
  end

`ifdef PIPE_CTRL_PERF_EN
  // Count cycles with the PC held; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (!we_pc) begin
      stall_cnt <= 32'(stall_cnt + 32'd1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a vector table for single-cycle decisions
// plus hand-written sequences for stalls, MDU wait/timeout and reset.
module tb_pipe_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_mem_read, ex_branch_taken, mdu_start, mdu_done, dmem_req, dmem_ready;

  logic we_pc, we_ifid, we_idex, we_exmem, we_memwb;
  logic flush_ifid, flush_idex, flush_exmem, flush_memwb, mdu_timeout;
  logic d4_we_pc, d4_we_ifid, d4_we_idex, d4_we_exmem, d4_we_memwb;
  logic d4_flush_ifid, d4_flush_idex, d4_flush_exmem, d4_flush_memwb, d4_mdu_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, d4_stall_cnt;
`endif

  int n_vec;
  int n_err;

  pipe_ctrl #(.REG_W(5), .MDU_MAX_CYC(64)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mdu_start(mdu_start), .mdu_done(mdu_done), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .we_pc(we_pc), .we_ifid(we_ifid), .we_idex(we_idex), .we_exmem(we_exmem), .we_memwb(we_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .flush_memwb(flush_memwb), .mdu_timeout(mdu_timeout)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  pipe_ctrl #(.REG_W(5), .MDU_MAX_CYC(4)) dut4 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mdu_start(mdu_start), .mdu_done(mdu_done), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .we_pc(d4_we_pc), .we_ifid(d4_we_ifid), .we_idex(d4_we_idex), .we_exmem(d4_we_exmem),
    .we_memwb(d4_we_memwb), .flush_ifid(d4_flush_ifid), .flush_idex(d4_flush_idex),
    .flush_exmem(d4_flush_exmem), .flush_memwb(d4_flush_memwb), .mdu_timeout(d4_mdu_timeout)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(d4_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {we pc,ifid,idex,exmem,memwb, flush ifid,idex,exmem,memwb, timeout}
  function automatic logic [9:0] outs();
    return {we_pc, we_ifid, we_idex, we_exmem, we_memwb,
            flush_ifid, flush_idex, flush_exmem, flush_memwb, mdu_timeout};
  endfunction

  function automatic logic [9:0] outs4();
    return {d4_we_pc, d4_we_ifid, d4_we_idex, d4_we_exmem, d4_we_memwb,
            d4_flush_ifid, d4_flush_idex, d4_flush_exmem, d4_flush_memwb, d4_mdu_timeout};
  endfunction

  localparam logic [9:0] O_ZERO = 10'b00000_0000_0;
  localparam logic [9:0] O_NORM = 10'b11111_0000_0;
  localparam logic [9:0] O_BR   = 10'b11111_1100_0;
  localparam logic [9:0] O_LU   = 10'b00111_0100_0;
  localparam logic [9:0] O_MDU  = 10'b00011_0010_0;
  localparam logic [9:0] O_TO   = 10'b11111_0000_1;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       mr, br, ms, md, dq, dy;
    logic [9:0] exp;
  } vec_t;

  function automatic vec_t mk(logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic mr, logic br, logic ms, logic md,
                              logic dq, logic dy, logic [9:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.mr = mr; v.br = br; v.ms = ms; v.md = md; v.dq = dq; v.dy = dy;
    v.exp = exp;
    return v;
  endfunction

  task automatic drive(vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; ex_rd = v.rd;
    ex_mem_read = v.mr; ex_branch_taken = v.br; mdu_start = v.ms;
    mdu_done = v.md; dmem_req = v.dq; dmem_ready = v.dy;
  endtask

  task automatic idle();
    drive(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM));
  endtask

  task automatic chk(string nm, logic [9:0] act, logic [9:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Sample at the falling edge, then advance past the next rising edge.
  task automatic step_chk(string nm, logic [9:0] exp);
    @(negedge clk);
    chk(nm, outs(), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    #1;
    chk("reset_outs", outs(), O_ZERO);
    chk("reset_outs4", outs4(), O_ZERO);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t vt[19];
  int   lowpc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    // rs1 rs2 rd mr br ms md dq dy expected
    vt[0]  = mk(5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 0, 0, O_NORM); // load, no match
    vt[1]  = mk(5'd1, 5'd5, 5'd5, 1, 0, 0, 0, 0, 0, O_LU);   // load x5 vs rs2
    vt[2]  = mk(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 0, O_NORM); // back to normal
    vt[3]  = mk(5'd7, 5'd2, 5'd7, 1, 0, 0, 0, 0, 0, O_LU);   // match on rs1
    vt[4]  = mk(5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0, O_NORM); // x0 never hazards
    vt[5]  = mk(5'd5, 5'd5, 5'd5, 0, 0, 0, 0, 0, 0, O_NORM); // match but not a load
    vt[6]  = mk(5'd1, 5'd5, 5'd5, 1, 1, 0, 0, 0, 0, O_BR);   // branch beats load-use
    vt[7]  = mk(5'd1, 5'd2, 5'd3, 0, 1, 0, 0, 0, 0, O_BR);   // branch alone
    vt[8]  = mk(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, 1, O_NORM); // mem ready at once
    vt[9]  = mk(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, 0, O_ZERO); // mem stall begins
    vt[10] = mk(5'd1, 5'd2, 5'd3, 0, 1, 0, 0, 1, 0, O_ZERO); // branch ignored in wait
    vt[11] = mk(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, 0, O_ZERO); // third stall cycle
    vt[12] = mk(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, 1, O_NORM); // ready releases
    vt[13] = mk(5'd1, 5'd2, 5'd3, 0, 0, 1, 0, 1, 0, O_ZERO); // mem beats mdu launch
    vt[14] = mk(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, 1, O_NORM); // ready releases
    vt[15] = mk(5'd1, 5'd2, 5'd3, 0, 1, 1, 0, 0, 0, O_MDU);  // mdu beats branch
    vt[16] = mk(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, 0, O_MDU);  // mem stall ignored
    vt[17] = mk(5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 0, 0, O_NORM); // mdu done
    vt[18] = mk(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 0, O_NORM); // back in RUN

    do_reset();
    foreach (vt[i]) begin
      drive(vt[i]);
      step_chk($sformatf("vec%0d", i), vt[i].exp);
    end

    // MDU wait: launch, 10 waiting cycles, done on the following cycle.
    do_reset();
    lowpc = 0;
    idle(); mdu_start = 1'b1;
    @(negedge clk);
    chk("mdu_launch", outs(), O_MDU);
    if (!we_pc) lowpc++;
    @(posedge clk); #1;
    idle();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("mdu_wait%0d", k), outs(), O_MDU);
      if (!we_pc) lowpc++;
      @(posedge clk); #1;
    end
    mdu_done = 1'b1;
    step_chk("mdu_done", O_NORM);
    idle();
    chk_int("mdu_pc_hold_cycles", lowpc, 11);
    ex_branch_taken = 1'b1;
    step_chk("mdu_after_run", O_BR);

    // Timeout with MDU_MAX_CYC=4: four wait cycles, the last one pulses.
    do_reset();
    idle(); mdu_start = 1'b1;
    @(negedge clk);
    chk("to_launch", outs4(), O_MDU);
    @(posedge clk); #1;
    idle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("to_wait%0d", k), outs4(), (k == 3) ? O_TO : O_MDU);
      @(posedge clk); #1;
    end
    ex_branch_taken = 1'b1;
    @(negedge clk);
    chk("to_after_run", outs4(), O_BR);
    @(posedge clk); #1;

    // Done on the same cycle the limit is reached: no timeout pulse.
    do_reset();
    idle(); mdu_start = 1'b1;
    @(posedge clk); #1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    mdu_done = 1'b1;
    @(negedge clk);
    chk("done_at_limit", outs4(), O_NORM);
    @(posedge clk); #1;
    idle();

    // Reset in the middle of a memory stall.
    do_reset();
    idle(); dmem_req = 1'b1;
    step_chk("rst_mem_enter", O_ZERO);
    step_chk("rst_mem_wait", O_ZERO);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_stall", outs(), O_ZERO);
`ifdef PIPE_CTRL_PERF_EN
    chk_int("rst_stall_cnt", int'(stall_cnt), 0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle(); ex_branch_taken = 1'b1;
    #1;
    chk("rst_release_run", outs(), O_BR);
    @(posedge clk); #1;
    idle();
    step_chk("rst_after_norm", O_NORM);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, meaning register-address width.
REQ-002 SHALL have parameter MDU_MAX_CYC, default 64, meaning the maximum cycles to wait for mdu_done before timeout.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have ports id_rs1 and id_rs2, input, REG_W each, meaning the source registers of the instruction in ID.
REQ-006 SHALL have port ex_rd, input, REG_W, meaning the destination register of the instruction in EX.
REQ-007 SHALL have port ex_mem_read, input, 1, meaning the instruction in EX is a load.
REQ-008 SHALL have port ex_branch_taken, input, 1, meaning the instruction in EX redirects the PC.
REQ-009 SHALL have port mdu_start, input, 1, meaning the instruction in EX launches a multi-cycle mul/div.
REQ-010 SHALL have port mdu_done, input, 1, meaning a one-cycle pulse when the MDU result is valid.
REQ-011 SHALL have ports dmem_req and dmem_ready, input, 1 each, meaning the MEM-stage access request and its completion.
REQ-012 SHALL have ports we_pc, we_ifid, we_idex, we_exmem and we_memwb, output, 1 each, meaning pipeline-register write enables.
REQ-013 SHALL have ports flush_ifid, flush_idex, flush_exmem and flush_memwb, output, 1 each, meaning pipeline-register flushes, effective only with the matching we high.
REQ-014 SHALL have port mdu_timeout, output, 1, meaning a one-cycle pulse on an MDU wait timeout.

Function
REQ-015 SHALL implement FSM states RUN, MEM_WAIT and MDU_WAIT; outputs are combinational from state and inputs; the state is registered.
REQ-016 SHALL apply priority in RUN: memory stall, then MDU launch, then branch, then load-use, then normal.
REQ-017 Normal: SHALL drive all we=1 and all flush=0.
REQ-018 Memory stall: in RUN, dmem_req=1 and dmem_ready=0 SHALL drive all we=0 and go to MEM_WAIT.
REQ-019 In MEM_WAIT, SHALL drive all we=0 while dmem_ready=0; dmem_ready=1 SHALL drive all we=1 that cycle and return to RUN.
REQ-020 MDU launch: mdu_start=1 in RUN SHALL drive we_pc/we_ifid/we_idex=0, we_exmem=1 with flush_exmem=1, and we_memwb=1, then go to MDU_WAIT.
REQ-021 In MDU_WAIT, SHALL hold the REQ-020 outputs each cycle until mdu_done=1; on mdu_done, all we=1, no flush, and return to RUN.
REQ-022 MDU_WAIT SHALL count cycles; on reaching MDU_MAX_CYC without mdu_done, SHALL pulse mdu_timeout for one cycle, behave as on mdu_done, and return to RUN.
REQ-023 mdu_done and timeout reached in the same cycle SHALL be treated as done, with no timeout pulse.
REQ-024 A memory stall arising during MDU_WAIT SHALL be ignored; MEM holds a bubble.
REQ-025 Branch: ex_branch_taken=1 SHALL drive all we=1, flush_ifid=1 and flush_idex=1.
REQ-026 Load-use: ex_mem_read=1, ex_rd!=0 and ex_rd equal to id_rs1 or id_rs2 SHALL drive we_pc=0, we_ifid=0, we_idex=1 with flush_idex=1, and we_exmem/we_memwb=1.
REQ-027 A branch coinciding with a load-use hazard SHALL take the branch action only.
REQ-028 flush_memwb SHALL always be 0; the port is reserved.

Reset
REQ-029 While rst=0, SHALL set state=RUN, clear the MDU counter, drive all we=0, all flush=0 and mdu_timeout=0.
REQ-030 Reset asserted mid-stall SHALL abandon the wait immediately; after release, the first edge evaluates in RUN.

Configuration
REQ-031 With PIPE_CTRL_PERF_EN defined, SHALL add output stall_cnt, 32-bit, incrementing every cycle in which we_pc=0, wrapping at 2^32-1 to 0, and cleared on reset.
REQ-032 Without PIPE_CTRL_PERF_EN, SHALL have no stall_cnt port and no counter logic.

Verification
REQ-033 Load x5 in EX with ex_rd=5 and id_rs2=5 -> one cycle of we_pc=0, we_ifid=0 and flush_idex=1, then normal.
REQ-034 ex_branch_taken=1 together with the REQ-033 hazard -> flush_ifid=1, flush_idex=1, we_pc=1 and no stall.
REQ-035 dmem_req=1 with dmem_ready low for 3 cycles -> 3 cycles of all we=0, then all we=1 on the ready cycle.
REQ-036 mdu_start, then mdu_done 10 cycles later -> we_pc=0 for 11 cycles, flush_exmem=1 throughout, and RUN afterwards.
REQ-037 MDU_MAX_CYC=4 with no mdu_done -> mdu_timeout pulses once and the FSM returns to RUN.
REQ-038 rst=0 asserted in MEM_WAIT -> outputs reach reset values immediately; with PIPE_CTRL_PERF_EN, stall_cnt=0.
